// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter that forwards one requester's access
// to a single downstream decoder port, with a bounded wait for dec_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_we              per-requester request level and write enable
//   req_addr, req_wdata      per-requester address/data, slice i belongs to requester i
//   gnt, done, err           one-hot grant, completion pulse, timeout pulse
//   rdata                    read data, valid while done is high
//   dec_valid, dec_we,
//   dec_addr, dec_wdata      downstream transaction
//   dec_ready, dec_rdata     downstream completion and read data
module decoder_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rdata,
  output logic                 dec_valid,
  output logic                 dec_we,
  output logic [AW-1:0]        dec_addr,
  output logic [DW-1:0]        dec_wdata,
  input  logic                 dec_ready,
  input  logic [DW-1:0]        dec_rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [NREQ-1:0] r_done, w_done;
  logic            r_err, w_err;
  logic [DW-1:0]   r_rdata, w_rdata;
  logic            r_valid, w_valid;
  logic            r_we, w_we;
  logic [AW-1:0]   r_addr, w_addr;
  logic [DW-1:0]   r_wdata, w_wdata;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [IW-1:0]   r_gidx, w_gidx;
  logic [IW-1:0]   r_last, w_last;

  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;
  logic            w_any;

  // Round-robin pick: scan from last+NREQ down to last+1 so the nearest
  // index after last_granted is the final (winning) assignment.
  always_comb begin
    w_win = r_last;
    w_idx = '0;
    w_any = |req;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (req[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_done  = '0;
    w_err   = 1'b0;
    w_rdata = r_rdata;
    w_valid = r_valid;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_cnt   = r_cnt;
    w_gidx  = r_gidx;
    w_last  = r_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state        = ISSUE;
          w_gnt          = '0;
          w_gnt[w_win]   = 1'b1;
          w_gidx         = w_win;
          w_we           = req_we[w_win];
          w_addr         = req_addr[int'(w_win)*AW +: AW];
          w_wdata        = req_wdata[int'(w_win)*DW +: DW];
          w_valid        = 1'b1;
          w_cnt          = '0;
        end
      end
      ISSUE: begin
        // dec_ready wins over a simultaneous timeout
        if (dec_ready) begin
          w_state = DONE;
          w_done  = r_gnt;
          w_valid = 1'b0;
          if (!r_we) begin
            w_rdata = dec_rdata;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state = DONE;
          w_done  = r_gnt;
          w_err   = 1'b1;
          w_valid = 1'b0;
          w_rdata = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_last  = r_gidx;
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_valid = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_valid <= w_valid;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_cnt   <= w_cnt;
      r_gidx  <= w_gidx;
      r_last  <= w_last;
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign dec_valid = r_valid;
  assign dec_we    = r_we;
  assign dec_addr  = r_addr;
  assign dec_wdata = r_wdata;

endmodule
